// File: rtl/alu_issue_stage_pkg.sv
// Shared pipeline types for the integer ALU issue path: ALU codes, operand
// width, the issue-queue entry layout and the operand-select encoding.
// Latency: n/a (types only). Backpressure: n/a.
package alu_issue_stage_pkg;

  localparam int BASIC_DATA_W = 32;
  localparam int RIDX_W       = 5;
  localparam int ALU_CODE_W   = 4;

  typedef logic [BASIC_DATA_W-1:0] BasicData;

  // IntALU operation codes; ALU_NONE is the idle/reset code.
  localparam logic [ALU_CODE_W-1:0] ALU_NONE = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 4'd6;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 4'd7;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 4'd8;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'd9;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 4'd10;

  // Operand source: the register value, or the alternate (pc / imm).
  typedef enum logic {
    OP_REG = 1'b0,
    OP_ALT = 1'b1
  } OpSel;

  typedef struct packed {
    logic [ALU_CODE_W-1:0] alucode;
    BasicData              op1;
    BasicData              op2;
    logic [RIDX_W-1:0]     rs1;
    logic [RIDX_W-1:0]     rs2;
    logic                  op1_is_reg;
    logic                  op2_is_reg;
    logic [RIDX_W-1:0]     rd;
  } IssueEntry;

  localparam IssueEntry ENTRY_RESET = '{alucode: ALU_NONE, default: '0};

endpackage

// File: rtl/alu_issue_operand_resolve.sv
// Resolves one ALU operand: x0 forces zero, a same-cycle writeback bypasses the
// regfile, then the select bit may replace the result with pc/imm.
// Latency: combinational. Backpressure: none.
// Ports: rs_idx_i, rf_data_i (regfile read), wb_valid_i/wb_rd_i/wb_data_i
// (writeback), sel_i (0=register, 1=alternate), alt_data_i, operand_o.
module alu_issue_operand_resolve
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_W    = BASIC_DATA_W,
  parameter int REG_IDX_W = RIDX_W
) (
  input  logic [REG_IDX_W-1:0] rs_idx_i,
  input  logic [DATA_W-1:0]    rf_data_i,
  input  logic                 wb_valid_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0]    wb_data_i,
  input  logic                 sel_i,
  input  logic [DATA_W-1:0]    alt_data_i,
  output logic [DATA_W-1:0]    operand_o
);

  logic [DATA_W-1:0] reg_val;

  always_comb begin
    reg_val = rf_data_i;
    if (rs_idx_i == '0) begin
      // x0 wins even over a writeback that targets it.
      reg_val = '0;
    end else if (wb_valid_i && (wb_rd_i == rs_idx_i)) begin
      reg_val = wb_data_i;
    end
    operand_o = (OpSel'(sel_i) == OP_ALT) ? alt_data_i : reg_val;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage feeding the IntALU: resolves op1/op2 and buffers ops in a 2-entry skid queue.
// Latency: op accepted at edge N is presented on out_* from cycle N+1 (head register).
// Backpressure: in_ready is registered (count<2), independent of out_ready in the same cycle.
// Ports: clk, rst_n (sync, active low), flush; upstream in_valid/in_ready with
// in_alucode, in_op1_sel, in_op2_sel, in_rs1, in_rs2, in_rd, in_pc, in_imm;
// regfile rf_rs1_data/rf_rs2_data; writeback wb_valid/wb_rd/wb_data;
// downstream out_valid/out_ready with out_alucode, out_op1, out_op2, out_rd.
// Optional: RISKY2_ISSUE_WB_SNOOP_EN lets buffered register operands pick up
// writebacks that land while they wait; otherwise operands freeze at capture.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_W    = BASIC_DATA_W,
  parameter int REG_IDX_W = RIDX_W,
  parameter int DEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CODE_W-1:0] in_alucode,
  input  logic                  in_op1_sel,
  input  logic                  in_op2_sel,
  input  logic [REG_IDX_W-1:0]  in_rs1,
  input  logic [REG_IDX_W-1:0]  in_rs2,
  input  logic [REG_IDX_W-1:0]  in_rd,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [DATA_W-1:0]     rf_rs1_data,
  input  logic [DATA_W-1:0]     rf_rs2_data,
  input  logic                  wb_valid,
  input  logic [REG_IDX_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_CODE_W-1:0] out_alucode,
  output logic [DATA_W-1:0]     out_op1,
  output logic [DATA_W-1:0]     out_op2,
  output logic [REG_IDX_W-1:0]  out_rd
);

  // Entry 0 is always the head; entry 1 only holds data when count_q==2.
  IssueEntry   head_q, head_d;
  IssueEntry   tail_q, tail_d;
  IssueEntry   head_s, tail_s;
  IssueEntry   new_ent;
  logic [1:0]  count_q, count_d;
  logic        in_ready_q, in_ready_d;
  logic        push, pop;
  logic [DATA_W-1:0] op1_res, op2_res;

  alu_issue_operand_resolve #(.DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W)) u_res_op1 (
    .rs_idx_i   (in_rs1),
    .rf_data_i  (rf_rs1_data),
    .wb_valid_i (wb_valid),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_data),
    .sel_i      (in_op1_sel),
    .alt_data_i (in_pc),
    .operand_o  (op1_res)
  );

  alu_issue_operand_resolve #(.DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W)) u_res_op2 (
    .rs_idx_i   (in_rs2),
    .rf_data_i  (rf_rs2_data),
    .wb_valid_i (wb_valid),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_data),
    .sel_i      (in_op2_sel),
    .alt_data_i (in_imm),
    .operand_o  (op2_res)
  );

  always_comb begin
    new_ent            = ENTRY_RESET;
    new_ent.alucode    = in_alucode;
    new_ent.op1        = op1_res;
    new_ent.op2        = op2_res;
    new_ent.rs1        = in_rs1;
    new_ent.rs2        = in_rs2;
    new_ent.op1_is_reg = (OpSel'(in_op1_sel) == OP_REG);
    new_ent.op2_is_reg = (OpSel'(in_op2_sel) == OP_REG);
    new_ent.rd         = in_rd;
  end

`ifdef RISKY2_ISSUE_WB_SNOOP_EN
  function automatic IssueEntry snoop(input IssueEntry e, input logic vld,
                                      input logic wv, input logic [REG_IDX_W-1:0] wrd,
                                      input logic [DATA_W-1:0] wdat);
    IssueEntry r;
    r = e;
    if (vld && wv) begin
      if (e.op1_is_reg && (e.rs1 != '0) && (wrd == e.rs1)) r.op1 = wdat;
      if (e.op2_is_reg && (e.rs2 != '0) && (wrd == e.rs2)) r.op2 = wdat;
    end
    return r;
  endfunction

  always_comb begin
    head_s = snoop(head_q, count_q != 2'd0, wb_valid, wb_rd, wb_data);
    tail_s = snoop(tail_q, count_q == 2'd2, wb_valid, wb_rd, wb_data);
  end
`else
  always_comb begin
    head_s = head_q;
    tail_s = tail_q;
  end
`endif

  assign out_valid   = (count_q != 2'd0);
  assign in_ready    = in_ready_q;
  assign push        = in_valid & in_ready_q;
  assign pop         = out_valid & out_ready;
  assign out_alucode = head_q.alucode;
  assign out_op1     = head_q.op1;
  assign out_op2     = head_q.op2;
  assign out_rd      = head_q.rd;

  always_comb begin
    head_d  = head_s;
    tail_d  = tail_s;
    count_d = count_q;
    if (pop) begin
      head_d  = tail_s;
      count_d = count_q - 2'd1;
    end
    if (push) begin
      // New op lands in the first free slot after any pop shift.
      if (count_d == 2'd0) head_d = new_ent;
      else                 tail_d = new_ent;
      count_d = count_d + 2'd1;
    end
    if (flush) begin
      // Entries are left stale; out_valid gates them via the count.
      count_d = 2'd0;
    end
    in_ready_d = (count_d < 2'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= ENTRY_RESET;
      tail_q     <= ENTRY_RESET;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [3:0]  in_alucode;
  logic        in_op1_sel, in_op2_sel;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_pc, in_imm, rf_rs1_data, rf_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [3:0]  out_alucode;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_alucode(in_alucode),
    .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_pc(in_pc), .in_imm(in_imm),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alucode(out_alucode),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd)
  );

  // Reference model: a FIFO of ops with their source registers kept for snooping.
  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  ra;
    logic [4:0]  rb;
    bit          a_reg;
    bit          b_reg;
    logic [4:0]  dst;
  } op_t;

  op_t mq[$];
  bit  m_ready = 0;

  function automatic logic [31:0] pick(logic [4:0] rs, logic [31:0] rf, bit sel, logic [31:0] alt);
    if (sel) return alt;
    if (rs == 0) return 32'd0;
    if (wb_valid && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  // Advance one clock, updating the model from the inputs currently driven.
  task automatic tick();
    op_t n;
    bit  do_push, do_pop;
    do_push = in_valid && m_ready;
    do_pop  = (mq.size() > 0) && out_ready;
    n.code  = in_alucode;
    n.a     = pick(in_rs1, rf_rs1_data, in_op1_sel, in_pc);
    n.b     = pick(in_rs2, rf_rs2_data, in_op2_sel, in_imm);
    n.ra    = in_rs1;
    n.rb    = in_rs2;
    n.a_reg = !in_op1_sel;
    n.b_reg = !in_op2_sel;
    n.dst   = in_rd;
`ifdef RISKY2_ISSUE_WB_SNOOP_EN
    if (wb_valid) begin
      foreach (mq[i]) begin
        if (mq[i].a_reg && mq[i].ra != 0 && mq[i].ra == wb_rd) mq[i].a = wb_data;
        if (mq[i].b_reg && mq[i].rb != 0 && mq[i].rb == wb_rd) mq[i].b = wb_data;
      end
    end
`endif
    if (!rst_n) begin
      mq.delete();
      m_ready = 0;
    end else if (flush) begin
      mq.delete();
      m_ready = 1;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(n);
      m_ready = (mq.size() < 2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(logic [3:0] code, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                        bit s1, bit s2, logic [31:0] d1, logic [31:0] d2,
                        logic [31:0] pc, logic [31:0] imm);
    in_valid = 1; in_alucode = code; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
    in_op1_sel = s1; in_op2_sel = s2; rf_rs1_data = d1; rf_rs2_data = d2;
    in_pc = pc; in_imm = imm;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); out_ready = 0;
    set_op(ALU_ADD, 5'd1, 5'd2, 5'd3, 0, 0, 32'h11, 32'h22, 32'h0, 32'h0);
    tick(); tick();
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    if (out_alucode !== ALU_NONE) begin errors++; $display("FAIL reset_alucode got %0h want %0h", out_alucode, ALU_NONE); end
    if (out_op1 !== 32'd0) begin errors++; $display("FAIL reset_op1 got %0h want 0", out_op1); end
    if (out_op2 !== 32'd0) begin errors++; $display("FAIL reset_op2 got %0h want 0", out_op2); end
    if (out_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0h want 0", out_rd); end
    idle(); rst_n = 1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic_and_bypass();
    out_ready = 1;
    set_op(ALU_ADD, 5'd5, 5'd9, 5'd4, 0, 1, 32'd10, 32'd77, 32'h100, 32'd3);
    tick(); idle();
    checks += 5;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", out_valid); end
    if (out_alucode !== ALU_ADD) begin errors++; $display("FAIL add_code got %0h want %0h", out_alucode, ALU_ADD); end
    if (out_op1 !== 32'd10) begin errors++; $display("FAIL add_op1 got %0h want a", out_op1); end
    if (out_op2 !== 32'd3) begin errors++; $display("FAIL add_op2 got %0h want 3", out_op2); end
    if (out_rd !== 5'd4) begin errors++; $display("FAIL add_rd got %0h want 4", out_rd); end
    // Same-cycle writeback bypass to rs1.
    set_op(ALU_SUB, 5'd5, 5'd0, 5'd6, 0, 0, 32'd10, 32'd0, 32'h0, 32'h0);
    wb_valid = 1; wb_rd = 5'd5; wb_data = 32'h55;
    tick(); idle();
    checks++;
    if (out_op1 !== 32'h55) begin errors++; $display("FAIL bypass_op1 got %0h want 55", out_op1); end
    // x0 ignores a writeback to r0.
    set_op(ALU_OR, 5'd0, 5'd0, 5'd7, 0, 0, 32'h123, 32'h0, 32'h0, 32'h0);
    wb_valid = 1; wb_rd = 5'd0; wb_data = 32'hFF;
    tick(); idle();
    checks++;
    if (out_op1 !== 32'd0) begin errors++; $display("FAIL x0_op1 got %0h want 0", out_op1); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    set_op(ALU_AND, 5'd1, 5'd2, 5'd11, 0, 0, 32'hA1, 32'hA2, 32'h0, 32'h0); tick();
    set_op(ALU_XOR, 5'd3, 5'd4, 5'd12, 0, 0, 32'hB1, 32'hB2, 32'h0, 32'h0); tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0b want 0", in_ready); end
    set_op(ALU_SLL, 5'd6, 5'd8, 5'd13, 0, 0, 32'hC1, 32'hC2, 32'h0, 32'h0); tick();
    idle(); out_ready = 1;
    checks += 2;
    if (out_rd !== 5'd11) begin errors++; $display("FAIL order_first got rd %0d want 11", out_rd); end
    if (out_op1 !== 32'hA1) begin errors++; $display("FAIL order_first_op1 got %0h want a1", out_op1); end
    tick();
    checks += 2;
    if (out_rd !== 5'd12) begin errors++; $display("FAIL order_second got rd %0d want 12", out_rd); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_return got %0b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL c_not_taken got valid %0b want 0", out_valid); end
  endtask

  task automatic test_snoop();
    logic [31:0] exp_b;
`ifdef RISKY2_ISSUE_WB_SNOOP_EN
    exp_b = 32'hABCD;
`else
    exp_b = 32'd1;
`endif
    out_ready = 0;
    set_op(ALU_ADD, 5'd0, 5'd0, 5'd1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0); tick();
    set_op(ALU_SUB, 5'd0, 5'd7, 5'd2, 0, 0, 32'h0, 32'd1, 32'h0, 32'h0); tick();
    idle(); wb_valid = 1; wb_rd = 5'd7; wb_data = 32'hABCD; tick();
    idle(); out_ready = 1; tick();
    checks += 2;
    if (out_rd !== 5'd2) begin errors++; $display("FAIL snoop_head got rd %0d want 2", out_rd); end
    if (out_op2 !== exp_b) begin errors++; $display("FAIL snoop_op2 got %0h want %0h", out_op2, exp_b); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 0;
    set_op(ALU_ADD, 5'd1, 5'd1, 5'd1, 0, 0, 32'h1, 32'h1, 32'h0, 32'h0); tick();
    set_op(ALU_ADD, 5'd2, 5'd2, 5'd2, 0, 0, 32'h2, 32'h2, 32'h0, 32'h0); tick();
    set_op(ALU_ADD, 5'd3, 5'd3, 5'd3, 0, 0, 32'h3, 32'h3, 32'h0, 32'h0);
    flush = 1; tick();
    idle(); out_ready = 1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet cycle %0d got %0b want 0", i, out_valid); end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_n       = (cyc != 300);
      flush       = ($urandom_range(0, 29) == 0);
      in_valid    = $urandom_range(0, 1);
      out_ready   = ($urandom_range(0, 3) != 0);
      in_alucode  = 4'($urandom_range(0, 10));
      in_rs1      = 5'($urandom_range(0, 7));
      in_rs2      = 5'($urandom_range(0, 7));
      in_rd       = 5'($urandom);
      in_op1_sel  = ($urandom_range(0, 3) == 0);
      in_op2_sel  = ($urandom_range(0, 2) == 0);
      in_pc       = $urandom;
      in_imm      = $urandom;
      rf_rs1_data = $urandom;
      rf_rs2_data = $urandom;
      wb_valid    = $urandom_range(0, 1);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      tick();
      checks += 2;
      if (out_valid !== (mq.size() > 0)) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", cyc, out_valid, mq.size() > 0);
      end
      if (in_ready !== m_ready) begin
        errors++; $display("FAIL rnd_in_ready cyc %0d got %0b want %0b", cyc, in_ready, m_ready);
      end
      if (mq.size() > 0) begin
        checks++;
        if (out_alucode !== mq[0].code || out_op1 !== mq[0].a || out_op2 !== mq[0].b || out_rd !== mq[0].dst) begin
          errors++;
          $display("FAIL rnd_head cyc %0d got %0h/%0h/%0h/%0h want %0h/%0h/%0h/%0h", cyc,
                   out_alucode, out_op1, out_op2, out_rd, mq[0].code, mq[0].a, mq[0].b, mq[0].dst);
        end
      end
    end
    rst_n = 1; idle();
  endtask

  initial begin
    test_reset();
    test_basic_and_bypass();
    test_back_to_back();
    test_snoop();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Producer side of the integer ALU operand interface. It accepts decoded ALU micro-ops, resolves the two operands (register file read, writeback bypass, x0, PC or immediate select) and buffers them in a 2-entry skid queue. It presents alucode, op1 and op2 to the IntALU with a valid/ready handshake. It sits between decode/regfile-read and execute.

Parameters:
- DATA_W, 32, operand width (BasicData)
- REG_IDX_W, 5, register index width
- DEPTH, 2, queue entries; fixed at 2, no other value supported

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  drop all buffered and incoming ops
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept
- in_alucode  in  4  ALU_* code from PipelineTypes
- in_op1_sel  in  1  0=rs1 value, 1=pc
- in_op2_sel  in  1  0=rs2 value, 1=imm
- in_rs1, in_rs2, in_rd  in  5 each  register indices
- in_pc, in_imm  in  32 each  PC and sign-extended immediate
- rf_rs1_data, rf_rs2_data  in  32 each  same-cycle regfile read of in_rs1/in_rs2
- wb_valid  in  1  writeback this cycle
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback value
- out_valid  out  1  head entry valid
- out_ready  in  1  ALU/execute accepts
- out_alucode  out  4  to IntALU alucode
- out_op1, out_op2  out  32 each  to IntALU op1/op2
- out_rd  out  5  destination, carried alongside

Behaviour:
- Reset (rst_n=0 at posedge):
  - count=0, out_valid=0, out_alucode=ALU_NONE, out_op1=out_op2=0, out_rd=0.
  - in_ready=0 while rst_n is low; in_ready=1 in the first cycle after release.
- Push = in_valid&in_ready. Pop = out_valid&out_ready.
- in_ready = (count<2). It is a registered function of count and does not depend combinationally on out_ready.
- Latency: an op accepted at edge N appears on out_* from cycle N+1. Outputs are driven from the head register only.
- Queue behaviour:
  - Order is FIFO.
  - count=1 with push and pop in the same cycle: count stays 1 and the new op becomes head.
  - count=0: push and pop cannot coincide.
  - Once count reaches 2 (full), in_ready drops the following cycle.
- Operand resolution at capture, in priority order:
  1. rs==0 -> 0.
  2. wb_valid & wb_rd==rs -> wb_data.
  3. Otherwise the regfile data.
- Operand select: sel bits then choose pc/imm over the resolved value.
- Each entry stores the final op1/op2, rs1/rs2 and op1_is_reg/op2_is_reg (= !sel).
- Flush: synchronous.
  - count is cleared to 0 and out_valid=0 the next cycle.
  - A push in the flush cycle is dropped.
  - A pop in the flush cycle is still considered taken by downstream.
- Reset mid-operation discards all entries. Reset has priority over flush.
- All arithmetic is width-exact. No ALU arithmetic is performed in this block.

Optional Feature:
- Macro: RISKY2_ISSUE_WB_SNOOP_EN.
- Defined: each cycle, every valid buffered entry with opN_is_reg & rsN!=0 & wb_valid & wb_rd==rsN has its opN overwritten with wb_data at the clock edge. This covers writebacks that land while an op waits under backpressure. An entry being pushed in the same cycle uses the capture-time bypass instead.
- Not defined: buffered operands are frozen at capture. Upstream must hold issue until the producer retires (scoreboard).

Decomposition:
- PipelineTypes (shared package):
  - Add IssueEntry struct: alucode, op1, op2, rs1, rs2, op1_is_reg, op2_is_reg, rd.
  - Add OpSel enum: OP_REG=0, OP_ALT=1.
  - ALU_* codes and BasicData remain in their existing packages.
- One combinational sub-module, alu_issue_operand_resolve: x0, bypass and select logic for one operand. It is instantiated twice.
- Queue and snoop logic live in the top module.

Test Plan:
- ADD, rs1=5 with rf=10, op2_sel=1, imm=3, out_ready=1 -> cycle after accept: out_valid=1, out_alucode=ALU_ADD, op1=10, op2=3.
- rs1=5 with rf=10 and wb_valid, wb_rd=5, wb_data=0x55 in the same cycle -> out_op1=0x55.
- rs1=0 with wb_rd=0, wb_data=0xFF -> out_op1=0.
- out_ready=0, push A then B -> in_ready=0 after B, a presented C is not accepted; out_ready=1 -> A then B emitted in order, in_ready returns to 1.
- Snoop: B buffered with rs2=7 (rf value 1), then wb rd=7 data 0xABCD while stalled -> out_op2=0xABCD with the macro defined, 1 without.
- Flush with count=2 and in_valid=1 -> out_valid=0 next cycle, nothing further emitted, in_ready=1.
